irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Programmable interrupt scheduler that drives the two PL-to-PS interrupt lines of the Zynq block design: a rising-edge interrupt and an active-high level interrupt.
- It replaces the free-running counter-decode interrupt logic in the design top.
- It enforces a guaranteed minimum gap between the edge and level events, so that Linux does not miss the level interrupt.
- The level interrupt is held until software acknowledges it or a timeout expires; overruns and timeouts are counted for debug.

Parameters:
- PERIOD, 120_000_000: event period in clk100 cycles, nominally 1.2 s at 100 MHz; legal range 2..2^32-1.
- EDGE_W, 256: cycles irq_edge stays high per event, minimum 1.
- GAP, 65536: idle cycles between irq_edge falling and irq_level rising, minimum 1.
- LVL_TMO, 10_000_000: maximum cycles irq_level is held without an ack, minimum 1.
- CNT_W, 32: width of the period/phase counters; must hold PERIOD-1, GAP, EDGE_W and LVL_TMO.

Ports:
- clk100  in  1  PS FCLK0, 100 MHz.
- rst_n  in  1  asynchronous active-low reset; release is synchronised externally to clk100.
- en  in  1  enables scheduling; sampled every cycle.
- lvl_ack  in  1  software ack (EMIO GPIO), already synchronous to clk100; any high cycle counts as an ack.
- irq_edge  out  1  to IRQ_F2P1, rising-edge interrupt.
- irq_level  out  1  to IRQ_F2P0, level interrupt.
- busy  out  1  high whenever the FSM is not in IDLE.
- ovr_cnt  out  16  count of dropped triggers, saturating.
- tmo_cnt  out  16  count of level timeouts, saturating.

Behaviour:
- Reset values: every output is 0; the period counter is 0; the FSM is in IDLE.
- Period counter: free-running while en=1, counting 0..PERIOD-1 and then wrapping to 0.
  - trig is asserted for one cycle when the counter equals PERIOD-1.
  - en=0 holds the counter at 0, so no trig is generated.
- FSM states are IDLE, EDGE, GAP, LEVEL; ph is the phase counter.
  - IDLE: on trig, go to EDGE with ph=0. irq_edge rises in the cycle after trig.
  - EDGE: irq_edge=1 for exactly EDGE_W cycles, then go to GAP with ph=0.
  - GAP: both outputs 0 for exactly GAP cycles, then go to LEVEL with ph=0.
  - LEVEL: irq_level=1. On lvl_ack=1, irq_level falls in the next cycle and the FSM returns to IDLE. On ph reaching LVL_TMO-1 without an ack, return to IDLE and increment tmo_cnt.
  - Ack and timeout in the same cycle: the ack wins and tmo_cnt is not incremented.
  - Otherwise ph increments by 1 each cycle within a state.
- Outputs are registered, decoded from the next state, and glitch-free.
- Trigger while busy: the trigger is dropped, ovr_cnt increments (saturating at 16'hFFFF), and the in-progress sequence is unaffected.
- lvl_ack outside LEVEL is ignored.
- en deasserted mid-sequence: the current sequence completes normally; only new triggers are suppressed.
- Asynchronous reset mid-sequence: both IRQ lines drop immediately (asynchronously) and the counters clear.
- Latency, trig to irq_level rise: EDGE_W+GAP+1 cycles.

Decomposition:
- Package irq_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, EDGE, GAP, LEVEL} irq_state_t;
  - localparam CNT16_MAX = 16'hFFFF.
- One natural sub-module, sat_cnt16: a saturating 16-bit event counter with async active-low reset and an inc input. It is instantiated twice, for ovr_cnt and tmo_cnt.

Test Plan:
- Basic sequence. PERIOD=1000, EDGE_W=8, GAP=20, LVL_TMO=100, en=1, lvl_ack pulsed 5 cycles after irq_level rises. Required:
  - irq_edge high for exactly 8 cycles, starting 1 cycle after the counter reaches 999.
  - irq_level rises 29 cycles after trig and falls 1 cycle after the ack.
  - Events repeat every 1000 cycles; both counters stay 0.
- Timeout. Same parameters, no lvl_ack. Required: irq_level high for exactly 100 cycles; tmo_cnt increments by 1 per period.
- Overrun. PERIOD=50, EDGE_W=8, GAP=20, LVL_TMO=100, no ack. Required: triggers during busy are dropped and counted in ovr_cnt; there is never a second irq_edge while busy=1.
- Simultaneous ack and timeout. Ack asserted exactly in the cycle ph=LVL_TMO-1. Required: tmo_cnt unchanged; FSM returns to IDLE.
- Enable and reset.
  - Deassert en during GAP: irq_level still asserts in that sequence, and no further irq_edge follows.
  - Assert rst_n=0 during LEVEL: irq_level goes to 0 with no clock edge, and all counters read 0.
- Saturation. Force ovr_cnt preloaded to 16'hFFFE via a bench hierarchical force, then cause 3 overruns. Required: ovr_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared state encoding and constants for the interrupt scheduler
package irq_sched_pkg;
   typedef enum logic [1:0] {IDLE, EDGE, GAP, LEVEL} irq_state_t;
   localparam logic [15:0] CNT16_MAX = 16'hFFFF;
endpackage

// File: rtl/irq_sched_sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at its maximum instead of wrapping
module sat_cnt16
   import irq_sched_pkg::*;
(
   input  logic        clk100,
   input  logic        rst_n,
   input  logic        inc,
   output logic [15:0] q
);
   always_ff @(posedge clk100 or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (inc && q != CNT16_MAX) q <= q + 16'd1;
endmodule

// File: rtl/irq_sched.sv
// irq_sched: periodic edge irq, fixed gap, then level irq held until ack or timeout
module irq_sched
   import irq_sched_pkg::*;
#(
   parameter int unsigned PERIOD  = 120_000_000,
   parameter int unsigned EDGE_W  = 256,
   parameter int unsigned GAP     = 65536,
   parameter int unsigned LVL_TMO = 10_000_000,
   parameter int unsigned CNT_W   = 32
)(
   input  logic        clk100,
   input  logic        rst_n,
   input  logic        en,
   input  logic        lvl_ack,
   output logic        irq_edge,
   output logic        irq_level,
   output logic        busy,
   output logic [15:0] ovr_cnt,
   output logic [15:0] tmo_cnt
);
   localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] E_LAST = CNT_W'(EDGE_W - 1);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LVL_TMO - 1);
   logic [CNT_W-1:0] cnt, ph;
   irq_state_t state, nxt;
   logic trig, tmo, edge_d, level_d, busy_d;
   assign trig = en && cnt == P_LAST;
   assign tmo  = state == LEVEL && !lvl_ack && ph == T_LAST;
   always_ff @(posedge clk100 or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (!en || cnt == P_LAST) ? '0 : cnt + CNT_W'(1);
   always_ff @(posedge clk100 or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         ph        <= '0;
         irq_edge  <= 1'b0;
         irq_level <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= nxt;
         ph        <= (nxt != state || state == IDLE) ? '0 : ph + CNT_W'(1);
         irq_edge  <= edge_d;
         irq_level <= level_d;
         busy      <= busy_d;
      end
   // ack takes priority over the timeout in the last LEVEL cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE:               nxt = trig ? EDGE : IDLE;
         EDGE:               nxt = ph == E_LAST ? irq_sched_pkg::GAP : EDGE;
         irq_sched_pkg::GAP: nxt = ph == G_LAST ? LEVEL : irq_sched_pkg::GAP;
         default:            nxt = (lvl_ack || ph == T_LAST) ? IDLE : LEVEL;
      endcase
   end
   always_comb begin
      edge_d  = nxt == EDGE;
      level_d = nxt == LEVEL;
      busy_d  = nxt != IDLE;
   end
   sat_cnt16 u_ovr (.clk100(clk100), .rst_n(rst_n), .inc(trig && state != IDLE), .q(ovr_cnt));
   sat_cnt16 u_tmo (.clk100(clk100), .rst_n(rst_n), .inc(tmo), .q(tmo_cnt));
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: cycle scoreboard on a 1000-cycle instance plus overrun/saturation on a 50-cycle one
module tb_irq_sched;
   localparam int P = 1000, EW = 8, GP = 20, LT = 100, LS = EW + GP + 1;
   logic clk100 = 1'b0, rst_n = 1'b0, en_a = 1'b0, ack_a = 1'b0, en_b = 1'b0, ack_b = 1'b0;
   logic edge_a, level_a, busy_a, edge_b, level_b, busy_b;
   logic [15:0] ovr_a, tmo_a, ovr_b, tmo_b;
   int errors = 0, checks = 0, cyc = 0, shown = 0, bad_b = 0, rise_b = 0;
   logic edge_b_q = 1'b0, busy_b_q = 1'b0;
   typedef struct packed { logic e, l, b; logic [15:0] o, t; } obs_t;
   typedef struct { int ack_d; int len; int tmo_d; } vec_t;
   obs_t exp_q[$];
   vec_t vt[5];
   int m_cnt, m_t;
   logic [15:0] m_ovr, m_tmo;
   logic m_trig;
   always #5 clk100 = ~clk100;
   always @(posedge clk100) cyc++;
   irq_sched #(.PERIOD(P), .EDGE_W(EW), .GAP(GP), .LVL_TMO(LT), .CNT_W(32)) dut_a (
      .clk100(clk100), .rst_n(rst_n), .en(en_a), .lvl_ack(ack_a), .irq_edge(edge_a),
      .irq_level(level_a), .busy(busy_a), .ovr_cnt(ovr_a), .tmo_cnt(tmo_a));
   irq_sched #(.PERIOD(50), .EDGE_W(EW), .GAP(GP), .LVL_TMO(LT), .CNT_W(32)) dut_b (
      .clk100(clk100), .rst_n(rst_n), .en(en_b), .lvl_ack(ack_b), .irq_edge(edge_b),
      .irq_level(level_b), .busy(busy_b), .ovr_cnt(ovr_b), .tmo_cnt(tmo_b));
   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask
   function automatic logic sig(input int s);
      return s == 0 ? edge_a : s == 1 ? level_a : s == 2 ? busy_b : edge_b;
   endfunction
   task automatic wait_sig(input int s, input logic v, input int lim, input string name);
      int n = 0;
      while (sig(s) !== v && n < lim) begin
         @(negedge clk100);
         n++;
      end
      check(name, longint'(sig(s)), longint'(v));
   endtask
   // reference model: m_t counts cycles since the accepted trigger, 0 when idle
   always @(posedge clk100 or negedge rst_n)
      if (!rst_n) begin
         m_cnt = 0;
         m_t   = 0;
         m_ovr = '0;
         m_tmo = '0;
         exp_q.delete();
      end else begin
         m_trig = en_a && m_cnt == P - 1;
         if (m_t > 0) begin
            if (m_trig && m_ovr != 16'hFFFF) m_ovr++;
            if (m_t >= LS && ack_a) m_t = 0;
            else if (m_t == LS + LT - 1) begin
               m_t = 0;
               if (m_tmo != 16'hFFFF) m_tmo++;
            end else m_t++;
         end else if (m_trig) m_t = 1;
         m_cnt = (!en_a || m_cnt == P - 1) ? 0 : m_cnt + 1;
         exp_q.push_back('{e: m_t >= 1 && m_t <= EW, l: m_t >= LS, b: m_t > 0, o: m_ovr, t: m_tmo});
      end
   always @(negedge clk100) begin
      obs_t w, a;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         a = {edge_a, level_a, busy_a, ovr_a, tmo_a};
         checks++;
         if (a !== w) begin
            errors++;
            if (shown < 10) $display("FAIL scoreboard cyc=%0d got %h want %h", cyc, a, w);
            shown++;
         end
      end
   end
   always @(negedge clk100) begin
      if (edge_b && !edge_b_q) begin
         rise_b++;
         if (busy_b_q) bad_b++;
      end
      edge_b_q = edge_b;
      busy_b_q = busy_b;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end
   initial begin
      int t_edge, t_prev, n;
      logic [15:0] tmo0;
      vt[0] = '{5, 6, 0};
      vt[1] = '{0, 1, 0};
      vt[2] = '{98, 99, 0};
      vt[3] = '{99, 100, 0};
      vt[4] = '{-1, 100, 1};
      repeat (3) @(negedge clk100);
      check("reset_a", longint'({edge_a, level_a, busy_a, ovr_a, tmo_a}), 0);
      check("reset_b", longint'({edge_b, level_b, busy_b, ovr_b, tmo_b}), 0);
      rst_n = 1'b1;
      en_a  = 1'b1;
      t_prev = -1;
      foreach (vt[i]) begin
         wait_sig(0, 1'b1, 2000, "edge_rise");
         t_edge = cyc;
         if (t_prev >= 0) check("period", longint'(t_edge - t_prev), longint'(P));
         t_prev = t_edge;
         n = 0;
         while (edge_a && n < 50) begin
            @(negedge clk100);
            n++;
         end
         check("edge_width", longint'(n), longint'(EW));
         wait_sig(1, 1'b1, 100, "level_rise");
         check("edge_to_level", longint'(cyc - t_edge), longint'(LS - 1));
         tmo0 = tmo_a;
         n = 0;
         while (level_a && n < 300) begin
            ack_a = (n == vt[i].ack_d);
            n++;
            @(negedge clk100);
         end
         ack_a = 1'b0;
         check("level_len", longint'(n), longint'(vt[i].len));
         check("tmo_delta", longint'(tmo_a - tmo0), longint'(vt[i].tmo_d));
         repeat (10) @(negedge clk100);
         ack_a = 1'b1;
         @(negedge clk100);
         ack_a = 1'b0;
      end
      check("ovr_a_zero", longint'(ovr_a), 0);
      wait_sig(0, 1'b1, 2000, "edge_rise_en");
      wait_sig(0, 1'b0, 50, "edge_fall_en");
      en_a = 1'b0;
      wait_sig(1, 1'b1, 100, "level_after_en_off");
      ack_a = 1'b1;
      @(negedge clk100);
      ack_a = 1'b0;
      n = 0;
      repeat (2500) begin
         @(negedge clk100);
         if (edge_a) n++;
      end
      check("no_edge_en_off", longint'(n), 0);
      en_b = 1'b1;
      repeat (420) @(negedge clk100);
      en_b = 1'b0;
      wait_sig(2, 1'b0, 300, "b_idle");
      check("ovr_b", longint'(ovr_b), 5);
      check("tmo_b", longint'(tmo_b), 3);
      check("edge_rises_b", longint'(rise_b), 3);
      @(negedge clk100);
      force dut_b.u_ovr.q = 16'hFFFE;
      #1 release dut_b.u_ovr.q;
      check("ovr_preload", longint'(ovr_b), 64'hFFFE);
      en_b = 1'b1;
      repeat (420) @(negedge clk100);
      en_b = 1'b0;
      wait_sig(2, 1'b0, 300, "b_idle2");
      check("ovr_saturated", longint'(ovr_b), 64'hFFFF);
      check("tmo_b2", longint'(tmo_b), 6);
      check("edge_while_busy", longint'(bad_b), 0);
      en_a = 1'b1;
      wait_sig(1, 1'b1, 2000, "level_before_rst");
      @(negedge clk100);
      #1 rst_n = 1'b0;
      #1 check("async_rst", longint'({edge_a, level_a, busy_a, ovr_a, tmo_a, ovr_b}), 0);
      @(negedge clk100);
      rst_n = 1'b1;
      en_a  = 1'b0;
      repeat (5) @(negedge clk100);
      check("post_rst_idle", longint'({busy_a, tmo_a, busy_b, tmo_b}), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
